// File: rtl/line_cache_sched.sv
// Four-slot line cache scheduler: tracks capture write slot and prev/cur/next read slots for the 3x3 window.
// Optional stall statistics counter is built when LINECACHE_STATS_EN is defined.
module line_cache_sched #(
    parameter int LINES     = 160,
    parameter int SLOT_BITS = 2
) (
    input  logic                 pxlClk,
    input  logic                 rst,
    input  logic                 newFrameIn,
    input  logic                 wrLineDone,
    input  logic                 nextLine,
    input  logic                 cacheUpdate,
    output logic [SLOT_BITS-1:0] wrSlot,
    output logic [SLOT_BITS-1:0] prevSlot,
    output logic [SLOT_BITS-1:0] curSlot,
    output logic [SLOT_BITS-1:0] nextSlot,
    output logic                 sameLine,
    output logic                 windowValid,
    output logic                 overflow,
    output logic [15:0]          stallCnt
);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    localparam logic [7:0] LAST_LINE = 8'(LINES - 1);
    localparam logic [7:0] PENULT    = 8'(LINES - 2);

    state_t               state_q, state_d;
    logic                 frame_q;
    logic                 fill_q, fill_d;
    logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [SLOT_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]           avail_q, avail_d;
    logic [7:0]           line_idx_q, line_idx_d;
    logic                 overflow_q, overflow_d;
    logic [SLOT_BITS-1:0] prev_q, cur_q, next_q;

    logic                 frame_rise;
    logic                 run_stall;
    logic                 accept;
    logic                 wr_ok;
    logic                 wr_ovf;
    logic [SLOT_BITS-1:0] prev_calc, next_calc;

    assign frame_rise = newFrameIn & ~frame_q;

    // avail==0 also stalls so the last-but-one line can never be accepted without its successor.
    assign run_stall = (line_idx_q == LAST_LINE) || (avail_q == 2'd0) ||
                       ((avail_q != 2'd2) && (line_idx_q < PENULT));

    assign accept = (state_q == S_RUN) && nextLine && !sameLine;
    // A same-cycle accepted read frees the prev slot, so the write may advance.
    assign wr_ok  = (state_q == S_RUN) && wrLineDone && ((avail_q != 2'd2) || accept);
    assign wr_ovf = (state_q == S_RUN) && wrLineDone && (avail_q == 2'd2) && !accept;

    assign prev_calc = (line_idx_q == 8'd0)   ? rd_ptr_q : rd_ptr_q - 1'b1;
    assign next_calc = (line_idx_q == LAST_LINE) ? rd_ptr_q : rd_ptr_q + 1'b1;

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_rise) begin
            state_d = S_PRIME;
        end else if (state_q == S_PRIME && wrLineDone && fill_q) begin
            state_d = S_RUN;
        end
    end

    always_comb begin
        windowValid = (state_q == S_RUN);
        sameLine    = (state_q == S_RUN) ? run_stall : 1'b1;
    end

    always_comb begin
        fill_d     = fill_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        avail_d    = avail_q;
        line_idx_d = line_idx_q;
        overflow_d = overflow_q | wr_ovf;
        if (frame_rise) begin
            fill_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            avail_d    = 2'd0;
            line_idx_d = 8'd0;
        end else if (state_q == S_PRIME) begin
            if (wrLineDone) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = 1'b1;
                if (fill_q) begin
                    rd_ptr_d = '0;
                    avail_d  = 2'd1;
                end
            end
        end else if (state_q == S_RUN) begin
            if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (accept) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                line_idx_d = line_idx_q + 8'd1;
            end
            case ({wr_ok, accept})
                2'b10:   avail_d = avail_q + 2'd1;
                2'b01:   avail_d = avail_q - 2'd1;
                default: avail_d = avail_q;
            endcase
        end
    end

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            frame_q    <= 1'b0;
            fill_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            avail_q    <= 2'd0;
            line_idx_q <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            frame_q    <= newFrameIn;
            fill_q     <= fill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            avail_q    <= avail_d;
            line_idx_q <= line_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Published selects only move on cacheUpdate so the window is stable during active video.
    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            cur_q  <= '0;
            next_q <= '0;
        end else if (cacheUpdate) begin
            prev_q <= prev_calc;
            cur_q  <= rd_ptr_q;
            next_q <= next_calc;
        end
    end

    assign wrSlot   = wr_ptr_q;
    assign prevSlot = prev_q;
    assign curSlot  = cur_q;
    assign nextSlot = next_q;
    assign overflow = overflow_q;

`ifdef LINECACHE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frame_rise) begin
            stall_cnt_d = 16'd0;
        end else if (nextLine && sameLine && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) stall_cnt_q <= 16'd0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stallCnt = stall_cnt_q;
`else
    assign stallCnt = 16'd0;
`endif

endmodule

// File: doc/line_cache_sched.md
# line_cache_sched

Schedules the four-slot line cache that feeds the scaler/smoother 3x3 window. It sits between the GBA capture writer and the HDMI image generator in the `pxlClk` domain. It tracks which slot the capture side is filling and which slots hold the previous, current and next GBA lines. It answers the image generator's `nextLine` requests and drives its `sameLine` stall flag.

## Interface
Parameters:
- `LINES`, 160, GBA lines per frame.
- `SLOT_BITS`, 2, log2 of slot count. The slot count is fixed at 4; other values are unsupported.

Ports:
- `pxlClk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `newFrameIn`  in  1  level from capture; its rising edge starts a frame.
- `wrLineDone`  in  1  one-cycle pulse when capture has completed a 240-pixel line.
- `nextLine`  in  1  one-cycle pulse; the image generator requests to advance to the next line.
- `cacheUpdate`  in  1  one-cycle pulse at the end of each HDMI line; publishes slot selects.
- `wrSlot`  out  2  slot currently being written by capture.
- `prevSlot`, `curSlot`, `nextSlot`  out  2 each  published read slots for the 3x3 window.
- `sameLine`  out  1  1 means a `nextLine` request is ignored this cycle.
- `windowValid`  out  1  cur and next lines hold valid data.
- `overflow`  out  1  sticky flag; capture outran the display side.
- `stallCnt`  out  16  stall statistics (see Configuration).

## Operation
- State machine: IDLE, PRIME, RUN. Reset state is IDLE.
- Internal registers:
  - `wrPtr` (2 bits), `rdPtr` (2 bits).
  - `avail` (0..2): complete lines after the current line.
  - `lineIdx` (8 bits): GBA line index of the current line.
- IDLE:
  - `wrLineDone` is ignored.
  - A rising edge of `newFrameIn` moves to PRIME and clears `wrPtr`, `rdPtr`, `avail` and `lineIdx` to 0.
- PRIME:
  - Each `wrLineDone` increments `wrPtr` and a fill count.
  - On the second `wrLineDone`, move to RUN with `rdPtr`=0, `avail`=1 and `wrPtr`=2.
- RUN, write side:
  - `wrLineDone` with `avail`<2: `wrPtr`+1 (mod 4) and `avail`+1.
  - `wrLineDone` with `avail`==2: the write would land on the prev slot. Set `overflow`, leave `wrPtr` unchanged (capture overwrites the same slot), and leave `avail` unchanged.
- RUN, read side:
  - `sameLine` = 1 when (`avail`<2 and `lineIdx`<`LINES`-2), or when `lineIdx`==`LINES`-1. Otherwise it is 0.
  - `nextLine` with `sameLine`==0 is accepted: `rdPtr`+1, `lineIdx`+1, `avail`-1.
  - At `lineIdx`==`LINES`-2, `avail`==1 is sufficient to accept.
- Simultaneous write and accepted read: `avail` is unchanged, and both pointers advance.
- An accepted `nextLine` at `lineIdx`==`LINES`-2 leaves `lineIdx`=`LINES`-1. The block stays in RUN until the next `newFrameIn` rising edge, which re-enters PRIME from any state.
- Edge clamping, computed from the internal pointers:
  - prev = `rdPtr`-1, or `rdPtr` when `lineIdx`==0.
  - next = `rdPtr`+1, or `rdPtr` when `lineIdx`==`LINES`-1.
- Publishing:
  - `prevSlot`, `curSlot` and `nextSlot` load from the internal values only on `cacheUpdate`, so they stay stable during active video.
  - `wrSlot` is `wrPtr` directly.
- `windowValid` = 1 in RUN and 0 otherwise.
- `sameLine` = 1 in IDLE and PRIME.
- `overflow` is cleared only by `rst`.
- All arithmetic on slots is mod 4, and wrap from 3 to 0 is required.

## Timing
- Reset values of all outputs are 0, except `sameLine`=1.
- `sameLine` and `windowValid` are combinational from registered state. They reflect an event at cycle t in cycle t+1.
- `wrSlot` updates in cycle t+1 after `wrLineDone` at cycle t.
- Published slots:
  - `cacheUpdate` at cycle t puts the internal values of cycle t onto the outputs at t+1.
  - If `nextLine` is accepted in the same cycle as `cacheUpdate`, the published value is the pre-advance pointer. The new pointer publishes at the next `cacheUpdate`.
- `nextLine` during `sameLine`=1 is dropped with no queuing.
- Asserting `rst` at any time immediately returns the block to IDLE with reset output values.

## Configuration
- `LINECACHE_STATS_EN` defined:
  - `stallCnt` counts cycles where `nextLine`=1 and `sameLine`=1.
  - The counter saturates at 0xFFFF.
  - It clears on `newFrameIn` rising edge and on `rst`.
- Not defined: `stallCnt` is tied to 0 and no counter logic is built.

## Test plan
- Prime: `newFrameIn` rise, then two `wrLineDone` pulses. Required: RUN; `windowValid`=1; `wrSlot`=2; `sameLine`=1 until a third `wrLineDone`, then 0. After `cacheUpdate`: prev=0, cur=0, next=1.
- Steady state: alternate `wrLineDone`/`nextLine` for 10 lines. Required: `curSlot` sequence 0,1,2,3,0,…; `overflow`=0.
- Overflow: in RUN with `avail`=2, pulse `wrLineDone`. Required: `overflow`=1; `wrSlot` unchanged; `overflow` stays set across `newFrameIn`.
- Simultaneous: `wrLineDone` and `nextLine` in the same cycle with `avail`=2. Required: `avail` stays 2; both pointers advance by 1; no overflow.
- Frame end: drive to `lineIdx`=159. Required: next clamp gives `nextSlot`=`curSlot`; `sameLine`=1; further `nextLine` is ignored. With `LINECACHE_STATS_EN`, 5 ignored pulses give `stallCnt`=5.
- Mid-frame restart: `newFrameIn` rise during RUN at `lineIdx`=40. Required: PRIME; `wrSlot`=0; `windowValid`=0 next cycle. Async `rst` mid-PRIME gives all outputs at reset values within the same cycle.
